leaves_mem_ctrl: RTL and testbench

Sequencer for port 0 of the leaf memory: 8 banks (one per leaf slot), each 256x64 1rw1r SRAM, with 64 leaves in use.
- Streams the sorted reference patches plus their indices into the banks, filling leaf-major and slot-minor.
- Arbitrates port 0 between this load stream and single-word wishbone readback.
- Port 1, the search read port, is not driven here.

---
 rtl/leaves_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_leaves_mem_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaves_mem_ctrl.sv
// Port-0 sequencer for the leaf memory: streams sorted patches into the per-slot
// banks (leaf-major, slot-minor) and interleaves single-word wishbone readback.
module leaves_mem_ctrl #(
    parameter int DATA_WIDTH = 11,
    parameter int IDX_WIDTH  = 9,
    parameter int LEAF_SIZE  = 8,
    parameter int PATCH_SIZE = 5,
    parameter int NUM_LEAVES = 64,
    parameter int LEAF_ADDRW = $clog2(NUM_LEAVES)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       load_start,
    output logic                                       load_busy,
    output logic                                       load_done,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [PATCH_SIZE*DATA_WIDTH-1:0]           in_patch,
    input  logic [IDX_WIDTH-1:0]                       in_idx,
    input  logic                                       wb_req,
    input  logic [LEAF_ADDRW+$clog2(LEAF_SIZE)-1:0]    wb_addr,
    output logic                                       wb_ack,
    output logic [63:0]                                wb_rdata,
    output logic [LEAF_SIZE-1:0]                       mem_csb0,
    output logic [LEAF_SIZE-1:0]                       mem_web0,
    output logic [LEAF_ADDRW-1:0]                      mem_addr0,
    output logic [PATCH_SIZE*DATA_WIDTH+IDX_WIDTH-1:0] mem_wleaf0,
    input  logic [LEAF_SIZE-1:0][63:0]                 mem_rleaf0
);
    localparam int SLOTW = $clog2(LEAF_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_ACK
    } state_t;

    state_t                r_state;
    logic [SLOTW-1:0]      r_slot;
    logic [LEAF_ADDRW-1:0] r_leaf;
    logic [SLOTW-1:0]      r_rd_slot;
    logic [LEAF_ADDRW-1:0] r_rd_leaf;

    logic [LEAF_SIZE-1:0]  w_wr_sel;
    logic [LEAF_SIZE-1:0]  w_rd_sel;
    logic [63:0]           w_rd_word;
    logic                  w_slot_last;
    logic                  w_last;

    // One-hot bank decode; an out-of-range read slot matches no bank at all.
    generate
        for (genvar gi = 0; gi < LEAF_SIZE; gi++) begin : g_sel
            assign w_wr_sel[gi] = (r_slot == SLOTW'(gi));
            assign w_rd_sel[gi] = (r_rd_slot == SLOTW'(gi));
        end
    endgenerate

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < LEAF_SIZE; i++) begin
            if (w_rd_sel[i]) begin
                w_rd_word = w_rd_word | mem_rleaf0[i];
            end
        end
    end

    assign w_slot_last = (r_slot == SLOTW'(LEAF_SIZE - 1));
    assign w_last      = w_slot_last && (r_leaf == LEAF_ADDRW'(NUM_LEAVES - 1));
    assign in_ready    = (r_state == S_LOAD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_slot     <= '0;
            r_leaf     <= '0;
            r_rd_slot  <= '0;
            r_rd_leaf  <= '0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            wb_ack     <= 1'b0;
            wb_rdata   <= '0;
            mem_csb0   <= '1;
            mem_web0   <= '1;
            mem_addr0  <= '0;
            mem_wleaf0 <= '0;
        end else begin
            load_done <= 1'b0;
            wb_ack    <= 1'b0;
            mem_csb0  <= '1;
            mem_web0  <= '1;
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_state   <= S_LOAD;
                        load_busy <= 1'b1;
                        r_slot    <= '0;
                        r_leaf    <= '0;
                    end else if (wb_req && !wb_ack) begin
                        // wb_ack high marks the ack cycle, where wb_req is still the old request
                        r_state   <= S_RD_ISSUE;
                        r_rd_slot <= wb_addr[SLOTW-1:0];
                        r_rd_leaf <= wb_addr[SLOTW +: LEAF_ADDRW];
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        mem_csb0   <= ~w_wr_sel;
                        mem_web0   <= ~w_wr_sel;
                        mem_addr0  <= r_leaf;
                        mem_wleaf0 <= {in_idx, in_patch};
                        if (w_slot_last) begin
                            r_slot <= '0;
                            r_leaf <= r_leaf + LEAF_ADDRW'(1);
                        end else begin
                            r_slot <= r_slot + SLOTW'(1);
                        end
                        if (w_last) begin
                            r_state   <= S_IDLE;
                            r_leaf    <= '0;
                            load_busy <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    mem_csb0  <= ~w_rd_sel;
                    mem_addr0 <= r_rd_leaf;
                    r_state   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    r_state <= S_RD_ACK;
                end
                S_RD_ACK: begin
                    wb_ack   <= 1'b1;
                    wb_rdata <= w_rd_word;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_leaves_mem_ctrl.sv
// Directed bench for leaves_mem_ctrl: behavioural 8-bank SRAM model plus a bus
// monitor; each task drives one scenario and checks against hand-derived values.
module tb_leaves_mem_ctrl;
    logic             clk;
    logic             rst_n;
    logic             load_start;
    logic             load_busy;
    logic             load_done;
    logic             in_valid;
    logic             in_ready;
    logic [54:0]      in_patch;
    logic [8:0]       in_idx;
    logic             wb_req;
    logic [8:0]       wb_addr;
    logic             wb_ack;
    logic [63:0]      wb_rdata;
    logic [7:0]       mem_csb0;
    logic [7:0]       mem_web0;
    logic [5:0]       mem_addr0;
    logic [63:0]      mem_wleaf0;
    logic [7:0][63:0] tb_rleaf;

    int n_vec;
    int n_err;

    leaves_mem_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_patch   (in_patch),
        .in_idx     (in_idx),
        .wb_req     (wb_req),
        .wb_addr    (wb_addr),
        .wb_ack     (wb_ack),
        .wb_rdata   (wb_rdata),
        .mem_csb0   (mem_csb0),
        .mem_web0   (mem_web0),
        .mem_addr0  (mem_addr0),
        .mem_wleaf0 (mem_wleaf0),
        .mem_rleaf0 (tb_rleaf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM banks: write and read both commit on the edge that samples csb low.
    logic [63:0] mem_model [8][64];
    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (!mem_csb0[b]) begin
                if (!mem_web0[b]) mem_model[b][mem_addr0] <= mem_wleaf0;
                else              tb_rleaf[b] <= mem_model[b][mem_addr0];
            end
        end
    end

    bit         mon_en;
    int         wr_cnt, rd_cnt, sel_err_cnt, done_cnt, done_bad_cnt, ack_cnt;
    logic [7:0] last_rd_csb;
    logic [5:0] last_rd_addr;
    always @(negedge clk) begin
        if (!mon_en) begin
            wr_cnt <= 0; rd_cnt <= 0; sel_err_cnt <= 0;
            done_cnt <= 0; done_bad_cnt <= 0; ack_cnt <= 0;
            last_rd_csb <= 8'hFF; last_rd_addr <= '0;
        end else begin
            if ($countones(~mem_csb0) > 1 || (~mem_web0 & mem_csb0) != 8'h00)
                sel_err_cnt <= sel_err_cnt + 1;
            if (mem_csb0 != 8'hFF && mem_web0 == mem_csb0) wr_cnt <= wr_cnt + 1;
            if (mem_csb0 != 8'hFF && mem_web0 == 8'hFF) begin
                rd_cnt       <= rd_cnt + 1;
                last_rd_csb  <= mem_csb0;
                last_rd_addr <= mem_addr0;
            end
            if (load_done) begin
                done_cnt <= done_cnt + 1;
                if (mem_csb0 != 8'h7F || mem_web0 != 8'h7F || mem_addr0 != 6'd63)
                    done_bad_cnt <= done_bad_cnt + 1;
            end
            if (wb_ack) ack_cnt <= ack_cnt + 1;
        end
    end

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_vec++; if (mem_csb0 !== 8'hFF) begin n_err++; $display("FAIL reset_csb: got %h expected ff", mem_csb0); end
        n_vec++; if (mem_web0 !== 8'hFF) begin n_err++; $display("FAIL reset_web: got %h expected ff", mem_web0); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_vec++; if (load_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", load_busy); end
        n_vec++; if (load_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", load_done); end
        n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b expected 0", wb_ack); end
        n_vec++; if (wb_rdata !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", wb_rdata); end
        n_vec++; if (mem_addr0 !== 6'h0 || mem_wleaf0 !== 64'h0) begin n_err++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", mem_addr0, mem_wleaf0); end
        n_vec++; if (wr_cnt + rd_cnt != 0) begin n_err++; $display("FAIL reset_idle_access: got %0d accesses expected 0", wr_cnt + rd_cnt); end
    endtask

    // Full 512-beat load of beat n = {idx n, patch 3n}; optionally raises wb_req with load_start.
    task automatic run_load(input bit bubbles, input bit with_req);
        int n, guard, bad_seq, bad_mem, first_bad, wr0, done0, dbad0, ack0;
        bit acc, tog;
        logic [7:0]  one, exp_sel;
        logic [63:0] exp_word;
        one = 8'h01;
        wr0 = wr_cnt; done0 = done_cnt; dbad0 = done_bad_cnt; ack0 = ack_cnt;
        load_start = 1'b1;
        if (with_req) begin
            wb_req  = 1'b1;
            wb_addr = {6'd63, 3'd7};
        end
        @(posedge clk);
        #1;
        load_start = 1'b0;
        n_vec++; if (load_busy !== 1'b1) begin n_err++; $display("FAIL load_busy_rise: got %b expected 1", load_busy); end
        n = 0; guard = 0; tog = 1'b0; bad_seq = 0;
        while (n < 512 && guard < 4000) begin
            tog      = ~tog;
            in_valid = bubbles ? tog : 1'b1;
            in_idx   = 9'(n);
            in_patch = 55'(n * 3);
            acc      = in_valid && in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (acc) begin
                exp_sel  = ~(one << (n % 8));
                exp_word = {9'(n), 55'(n * 3)};
                if (mem_csb0 !== exp_sel || mem_web0 !== exp_sel || mem_addr0 !== 6'(n / 8) || mem_wleaf0 !== exp_word)
                    bad_seq++;
                n++;
            end
        end
        in_valid = 1'b0;
        n_vec++; if (n != 512) begin n_err++; $display("FAIL load_beats: got %0d accepted expected 512", n); end
        n_vec++; if (bad_seq != 0) begin n_err++; $display("FAIL load_write_seq: got %0d bad beats expected 0", bad_seq); end
        n_vec++; if (load_done !== 1'b1 || load_busy !== 1'b0) begin n_err++; $display("FAIL load_end_status: got done=%b busy=%b expected done=1 busy=0", load_done, load_busy); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL load_end_ready: got %b expected 0", in_ready); end
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (load_done !== 1'b0) begin n_err++; $display("FAIL load_done_width: got %b expected 0", load_done); end
        n_vec++; if (done_cnt - done0 != 1 || done_bad_cnt - dbad0 != 0) begin n_err++; $display("FAIL load_done_pulse: got %0d pulses %0d misplaced expected 1 and 0", done_cnt - done0, done_bad_cnt - dbad0); end
        n_vec++; if (wr_cnt - wr0 != 512) begin n_err++; $display("FAIL load_write_count: got %0d expected 512", wr_cnt - wr0); end
        n_vec++; if (ack_cnt - ack0 != 0) begin n_err++; $display("FAIL load_no_ack: got %0d acks expected 0", ack_cnt - ack0); end
        bad_mem = 0; first_bad = -1;
        for (int k = 0; k < 512; k++) begin
            exp_word = {9'(k), 55'(k * 3)};
            if (mem_model[k % 8][k / 8] !== exp_word) begin
                bad_mem++;
                if (first_bad < 0) first_bad = k;
            end
        end
        n_vec++; if (bad_mem != 0) begin n_err++; $display("FAIL load_mem_contents: got %0d bad words (first beat %0d) expected 0", bad_mem, first_bad); end
    endtask

    task automatic test_load_b2b();
        run_load(1'b0, 1'b0);
    endtask

    task automatic test_load_bubbles();
        run_load(1'b1, 1'b0);
    endtask

    task automatic test_readback();
        int k, rd0;
        rd0     = rd_cnt;
        wb_addr = {6'd5, 3'd3};
        wb_req  = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!wb_ack && k < 20);
        n_vec++; if (k != 4) begin n_err++; $display("FAIL rd_latency: got ack at sample %0d expected 4", k); end
        n_vec++; if (wb_rdata !== {9'd43, 55'd129}) begin n_err++; $display("FAIL rd_data: got %h expected %h", wb_rdata, {9'd43, 55'd129}); end
        @(posedge clk);
        #1;
        n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL rd_ack_width: got %b expected 0", wb_ack); end
        wb_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_vec++; if (rd_cnt - rd0 != 1) begin n_err++; $display("FAIL rd_single_access: got %0d reads expected 1", rd_cnt - rd0); end
        n_vec++; if (last_rd_csb !== 8'hF7 || last_rd_addr !== 6'd5) begin n_err++; $display("FAIL rd_bank_addr: got csb=%h addr=%0d expected f7/5", last_rd_csb, last_rd_addr); end
        n_vec++; if (wb_rdata !== {9'd43, 55'd129}) begin n_err++; $display("FAIL rd_data_hold: got %h expected %h", wb_rdata, {9'd43, 55'd129}); end
    endtask

    task automatic test_load_and_read();
        int k, rd0;
        rd0 = rd_cnt;
        run_load(1'b0, 1'b1);
        k = 0;
        while (!wb_ack && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++; if (wb_ack !== 1'b1) begin n_err++; $display("FAIL lr_ack: got %b after %0d cycles expected 1", wb_ack, k); end
        n_vec++; if (wb_rdata !== {9'd511, 55'd1533}) begin n_err++; $display("FAIL lr_data: got %h expected %h", wb_rdata, {9'd511, 55'd1533}); end
        @(posedge clk);
        #1;
        wb_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_vec++; if (rd_cnt - rd0 != 1 || last_rd_csb !== 8'h7F || last_rd_addr !== 6'd63) begin n_err++; $display("FAIL lr_access: got %0d reads csb=%h addr=%0d expected 1/7f/63", rd_cnt - rd0, last_rd_csb, last_rd_addr); end
    endtask

    task automatic test_reset_mid_load();
        int n, guard, wr0;
        bit acc;
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        n = 0; guard = 0;
        while (n < 200 && guard < 1000) begin
            in_valid = 1'b1;
            in_idx   = 9'(n);
            in_patch = 55'(n * 3);
            acc      = in_valid && in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (acc) n++;
        end
        in_idx   = 9'd200;
        in_patch = 55'd600;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        wr0 = wr_cnt;
        n_vec++; if (mem_csb0 !== 8'hFF || mem_web0 !== 8'hFF) begin n_err++; $display("FAIL mid_reset_sel: got csb=%h web=%h expected ff/ff", mem_csb0, mem_web0); end
        n_vec++; if (mem_addr0 !== 6'h0 || mem_wleaf0 !== 64'h0) begin n_err++; $display("FAIL mid_reset_addr_data: got %h/%h expected 0/0", mem_addr0, mem_wleaf0); end
        n_vec++; if (in_ready !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0) begin n_err++; $display("FAIL mid_reset_status: got ready=%b busy=%b done=%b expected 0/0/0", in_ready, load_busy, load_done); end
        n_vec++; if (wb_ack !== 1'b0 || wb_rdata !== 64'h0) begin n_err++; $display("FAIL mid_reset_wb: got ack=%b rdata=%h expected 0/0", wb_ack, wb_rdata); end
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (wr_cnt != wr0) begin n_err++; $display("FAIL mid_reset_no_write: got %0d writes expected 0", wr_cnt - wr0); end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        run_load(1'b0, 1'b0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; mon_en = 1'b0;
        rst_n = 1'b0; load_start = 1'b0; in_valid = 1'b0;
        in_patch = '0; in_idx = '0; wb_req = 1'b0; wb_addr = '0;
        test_reset();
        test_load_b2b();
        test_readback();
        test_load_bubbles();
        test_load_and_read();
        test_reset_mid_load();
        n_vec++; if (sel_err_cnt != 0) begin n_err++; $display("FAIL bank_select_rules: got %0d bad cycles expected 0", sel_err_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
